instr_prefetch_unit: RTL and testbench

- Decoupled instruction fetch front end for the Z8-style core.
- Replaces the fixed FETCH/WAIT/READ sequencing with a parametrised byte prefetch queue that streams from the synchronous program memory.
- Presents one complete 1-, 2- or 3-byte instruction per handshake to the decode stage.
- Supports redirect (jp/jr taken, later call/ret) by flush.

---
 rtl/instr_prefetch_unit.sv | 112 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit
//   Decoupled instruction fetch front end. Streams bytes from a synchronous
//   program memory (one-cycle read latency) into a small byte queue and hands
//   the decode stage one complete 1/2/3-byte instruction per handshake.
//   A flush from execute empties the queue and restarts fetch at flushAddr.
//
// Ports
//   clk, resetN            clock, asynchronous active-low reset
//   memAddr, memStrobe     program memory read request
//   memDataRead            read data, valid the cycle after memStrobe
//   flush, flushAddr       redirect request and new fetch address
//   instrValid/instrReady  head-instruction handshake with decode
//   instrLen               1, 2 or 3 (0 while invalid)
//   instrBytes             {opcode, 2nd, 3rd}, unused bytes zero
//   instrPc                address of the opcode byte
module instr_prefetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  resetN,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  input  logic [7:0]            memDataRead,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flushAddr,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic [1:0]            instrLen,
  output logic [23:0]           instrBytes,
  output logic [ADDR_WIDTH-1:0] instrPc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [7:0]            q [DEPTH];
  logic [PW-1:0]         headPtr, tailPtr;
  logic [CW-1:0]         count;
  logic                  inFlight;
  logic [ADDR_WIDTH-1:0] fetchPc, headPc;

  logic [CW:0]  occ;
  logic [1:0]   headLen;
  logic         headValid, push, pop;
  logic [7:0]   b0, b1, b2;

  function automatic logic [1:0] decodeLen(input logic [7:0] op);
    case (op[3:0])
      4'hE, 4'hF:                    decodeLen = 2'd1;
      4'h4, 4'h5, 4'h6, 4'h7, 4'hD:  decodeLen = 2'd3;
      default:                       decodeLen = 2'd2;
    endcase
  endfunction

  // Bytes already queued plus the one still coming back from memory; the
  // outstanding read counts so a return can never land on a live slot.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inFlight};
  assign memStrobe = resetN & ~flush & (occ < DEPTH_W);
  assign memAddr   = fetchPc;

  assign b0        = q[headPtr];
  assign b1        = q[headPtr + PW'(1)];
  assign b2        = q[headPtr + PW'(2)];
  assign headLen   = decodeLen(b0);
  assign headValid = count >= CW'(headLen);

  assign instrValid = headValid & ~flush;
  assign instrLen   = instrValid ? headLen : 2'd0;
  assign instrBytes = instrValid ? {b0,
                                    (headLen >= 2'd2) ? b1 : 8'h00,
                                    (headLen == 2'd3) ? b2 : 8'h00} : 24'h0;
  assign instrPc    = headPc;

  // A return arriving in a flush cycle belongs to the old stream: drop it.
  assign push = inFlight & ~flush;
  assign pop  = instrValid & instrReady;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      inFlight <= 1'b0;
      fetchPc  <= RESET_PC;
      headPc   <= RESET_PC;
    end else if (flush) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      inFlight <= 1'b0;
      fetchPc  <= flushAddr;
      headPc   <= flushAddr;
    end else begin
      inFlight <= memStrobe;
      if (memStrobe) fetchPc <= fetchPc + ADDR_WIDTH'(1);
      if (push) begin
        q[tailPtr] <= memDataRead;
        tailPtr    <= tailPtr + PW'(1);
      end
      if (pop) begin
        headPtr <= headPtr + PW'(headLen);
        headPc  <= headPc + ADDR_WIDTH'(headLen);
      end
      count <= count + CW'(push) - (pop ? CW'(headLen) : '0);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] memAddr;
  logic        memStrobe;
  logic [7:0]  memDataRead = 8'h00;
  logic        flush;
  logic [15:0] flushAddr;
  logic        instrValid;
  logic        instrReady;
  logic [1:0]  instrLen;
  logic [23:0] instrBytes;
  logic [15:0] instrPc;

  logic [7:0]  memAddr8;
  logic        memStrobe8;
  logic [7:0]  memDataRead8 = 8'h00;
  logic        flush8;
  logic [7:0]  flushAddr8;
  logic        instrValid8;
  logic        ready8;
  logic [1:0]  instrLen8;
  logic [23:0] instrBytes8;
  logic [7:0]  instrPc8;

  logic [7:0] mem  [0:65535];
  logic [7:0] mem8 [0:255];

  int checks = 0;
  int failures = 0;

  logic [15:0] gPc    [0:7];
  logic [1:0]  gLen   [0:7];
  logic [23:0] gBytes [0:7];

  instr_prefetch_unit #(.ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
    .memDataRead(memDataRead), .flush(flush), .flushAddr(flushAddr),
    .instrValid(instrValid), .instrReady(instrReady), .instrLen(instrLen),
    .instrBytes(instrBytes), .instrPc(instrPc));

  instr_prefetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'hFE)) dut8 (
    .clk(clk), .resetN(resetN), .memAddr(memAddr8), .memStrobe(memStrobe8),
    .memDataRead(memDataRead8), .flush(flush8), .flushAddr(flushAddr8),
    .instrValid(instrValid8), .instrReady(ready8), .instrLen(instrLen8),
    .instrBytes(instrBytes8), .instrPc(instrPc8));

  always #5 clk = ~clk;

  // synchronous program memories, one-cycle read latency
  always @(posedge clk) if (memStrobe)  memDataRead  <= mem[memAddr];
  always @(posedge clk) if (memStrobe8) memDataRead8 <= mem8[memAddr8];

  function automatic logic [1:0] refLen(input logic [7:0] op);
    case (op[3:0])
      4'hE, 4'hF:                   return 2'd1;
      4'h4, 4'h5, 4'h6, 4'h7, 4'hD: return 2'd3;
      default:                      return 2'd2;
    endcase
  endfunction

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    resetN = 1'b0; flush = 1'b0; flushAddr = '0; instrReady = 1'b0;
    flush8 = 1'b0; flushAddr8 = '0; ready8 = 1'b0;
    repeat (2) nxt();
    resetN = 1'b1;
  endtask

  task automatic loadProg();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    mem[0] = 8'h0C; mem[1] = 8'h55; mem[2] = 8'hFF;
    mem[3] = 8'hE6; mem[4] = 8'h20; mem[5] = 8'hAA;
  endtask

  // Records accepted instructions of the 16-bit instance; samples mid-cycle.
  task automatic collect(input int want, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < want; c++) begin
      #1;
      if (instrValid && instrReady) begin
        gPc[got] = instrPc; gLen[got] = instrLen; gBytes[got] = instrBytes;
        got++;
      end
      nxt();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; flush = 1'b0; flushAddr = '0; instrReady = 1'b1;
    flush8 = 1'b0; flushAddr8 = '0; ready8 = 1'b0;
    nxt(); #1;
    checks++; if (memStrobe !== 1'b0) begin failures++; $display("FAIL rst_strobe: got %b want 0", memStrobe); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instrValid); end
    checks++; if (instrPc !== 16'h0000) begin failures++; $display("FAIL rst_pc: got %h want 0000", instrPc); end
    checks++; if (instrLen !== 2'd0) begin failures++; $display("FAIL rst_len: got %0d want 0", instrLen); end
    checks++; if (instrBytes !== 24'h0) begin failures++; $display("FAIL rst_bytes: got %h want 000000", instrBytes); end
    checks++; if (instrPc8 !== 8'hFE) begin failures++; $display("FAIL rst_pc8: got %h want fe", instrPc8); end
  endtask

  task automatic test_stream();
    logic [15:0] ePc [0:2];
    logic [1:0]  eLen [0:2];
    logic [23:0] eB [0:2];
    int got;
    ePc = '{16'h0000, 16'h0002, 16'h0003};
    eLen = '{2'd2, 2'd1, 2'd3};
    eB = '{24'h0C5500, 24'hFF0000, 24'hE620AA};
    loadProg();
    doReset();
    instrReady = 1'b1;
    collect(3, 40, got);
    checks++; if (got !== 3) begin failures++; $display("FAIL stream_count: got %0d want 3", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (gPc[i] !== ePc[i] || gLen[i] !== eLen[i] || gBytes[i] !== eB[i]) begin
        failures++;
        $display("FAIL stream_instr%0d: got pc %h len %0d bytes %h want pc %h len %0d bytes %h",
                 i, gPc[i], gLen[i], gBytes[i], ePc[i], eLen[i], eB[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] ePc [0:3];
    logic [1:0]  eLen [0:3];
    logic [23:0] eB [0:3];
    int strobes, got;
    ePc = '{16'h0000, 16'h0002, 16'h0003, 16'h0006};
    eLen = '{2'd2, 2'd1, 2'd3, 2'd1};
    eB = '{24'h0C5500, 24'hFF0000, 24'hE620AA, 24'hFF0000};
    loadProg();
    doReset();
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      #1; if (memStrobe) strobes++;
      nxt();
    end
    #1;
    checks++; if (strobes !== 4) begin failures++; $display("FAIL full_strobes: got %0d want 4", strobes); end
    checks++; if (memStrobe !== 1'b0) begin failures++; $display("FAIL full_stall: got %b want 0", memStrobe); end
    checks++; if (instrValid !== 1'b1 || instrPc !== 16'h0000) begin failures++; $display("FAIL full_head: got valid %b pc %h want 1 0000", instrValid, instrPc); end
    instrReady = 1'b1;
    collect(4, 40, got);
    checks++; if (got !== 4) begin failures++; $display("FAIL full_count: got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (gPc[i] !== ePc[i] || gLen[i] !== eLen[i] || gBytes[i] !== eB[i]) begin
        failures++;
        $display("FAIL full_instr%0d: got pc %h len %0d bytes %h want pc %h len %0d bytes %h",
                 i, gPc[i], gLen[i], gBytes[i], ePc[i], eLen[i], eB[i]);
      end
    end
  endtask

  task automatic test_flush();
    int got;
    loadProg();
    mem[16'h0040] = 8'hEE;
    mem[16'h0050] = 8'hD4; mem[16'h0051] = 8'h11; mem[16'h0052] = 8'h22;
    doReset();
    instrReady = 1'b1;
    #1;
    checks++; if (memStrobe !== 1'b1 || memAddr !== 16'h0000) begin failures++; $display("FAIL flush_first_issue: got %b %h want 1 0000", memStrobe, memAddr); end
    nxt();
    // byte 0 is returning in this cycle
    flush = 1'b1; flushAddr = 16'h0040;
    #1;
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", instrValid); end
    checks++; if (memStrobe !== 1'b0) begin failures++; $display("FAIL flush_strobe: got %b want 0", memStrobe); end
    nxt();
    flush = 1'b0;
    #1;
    checks++; if (memStrobe !== 1'b1 || memAddr !== 16'h0040) begin failures++; $display("FAIL flush_reissue: got %b %h want 1 0040", memStrobe, memAddr); end
    nxt(); #1;
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL flush_early: got %b want 0", instrValid); end
    nxt(); #1;
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 16'h0040 || instrLen !== 2'd1 || instrBytes !== 24'hEE0000) begin
      failures++;
      $display("FAIL flush_first_instr: got v %b pc %h len %0d bytes %h want 1 0040 1 ee0000",
               instrValid, instrPc, instrLen, instrBytes);
    end
    // back-to-back flushes: last address wins
    nxt();
    flush = 1'b1; flushAddr = 16'h0080;
    nxt();
    flushAddr = 16'h0050;
    nxt();
    flush = 1'b0;
    collect(1, 12, got);
    checks++;
    if (got !== 1 || gPc[0] !== 16'h0050 || gLen[0] !== 2'd3 || gBytes[0] !== 24'hD41122) begin
      failures++;
      $display("FAIL flush_b2b: got n %0d pc %h len %0d bytes %h want 1 0050 3 d41122",
               got, gPc[0], gLen[0], gBytes[0]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  wPc [0:1];
    logic [1:0]  wLen [0:1];
    logic [23:0] wB [0:1];
    int got;
    for (int i = 0; i < 256; i++) mem8[i] = 8'hFF;
    mem8[8'hFE] = 8'hD6; mem8[8'hFF] = 8'h12; mem8[8'h00] = 8'h34; mem8[8'h01] = 8'hFF;
    doReset();
    ready8 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      #1;
      if (instrValid8 && ready8) begin
        wPc[got] = instrPc8; wLen[got] = instrLen8; wB[got] = instrBytes8; got++;
      end
      nxt();
    end
    ready8 = 1'b0;
    checks++; if (got !== 2) begin failures++; $display("FAIL wrap_count: got %0d want 2", got); end
    if (got == 2) begin
      checks++;
      if (wPc[0] !== 8'hFE || wLen[0] !== 2'd3 || wB[0] !== 24'hD61234) begin
        failures++; $display("FAIL wrap_instr: got pc %h len %0d bytes %h want fe 3 d61234", wPc[0], wLen[0], wB[0]);
      end
      checks++;
      if (wPc[1] !== 8'h01 || wLen[1] !== 2'd1 || wB[1] !== 24'hFF0000) begin
        failures++; $display("FAIL wrap_next: got pc %h len %0d bytes %h want 01 1 ff0000", wPc[1], wLen[1], wB[1]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int got;
    loadProg();
    doReset();
    repeat (4) nxt();
    #1;
    // three bytes queued, fourth read outstanding
    checks++; if (instrValid !== 1'b1 || memStrobe !== 1'b0) begin failures++; $display("FAIL mid_pre: got v %b s %b want 1 0", instrValid, memStrobe); end
    resetN = 1'b0;
    #1;
    checks++; if (instrValid !== 1'b0 || memStrobe !== 1'b0) begin failures++; $display("FAIL mid_clear: got v %b s %b want 0 0", instrValid, memStrobe); end
    checks++; if (instrPc !== 16'h0000) begin failures++; $display("FAIL mid_pc: got %h want 0000", instrPc); end
    nxt();
    resetN = 1'b1;
    #1;
    checks++; if (memStrobe !== 1'b1 || memAddr !== 16'h0000) begin failures++; $display("FAIL mid_restart: got %b %h want 1 0000", memStrobe, memAddr); end
    instrReady = 1'b1;
    collect(1, 12, got);
    checks++;
    if (got !== 1 || gPc[0] !== 16'h0000 || gBytes[0] !== 24'h0C5500) begin
      failures++; $display("FAIL mid_resume: got n %0d pc %h bytes %h want 1 0000 0c5500", got, gPc[0], gBytes[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] modelPc, p1, p2;
    logic [1:0]  eLen;
    logic [23:0] eB;
    int occ, accepted, bad;
    logic acc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    doReset();
    modelPc = 16'h0000; occ = 0; accepted = 0;
    for (int c = 0; c < 30000 && accepted < 1000; c++) begin
      flush = ($urandom_range(0, 31) == 0);
      flushAddr = 16'($urandom);
      instrReady = ($urandom_range(0, 3) != 0);
      #1;
      acc = instrValid & instrReady;
      if (flush) begin
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rnd_flush_valid: got %b want 0", instrValid); end
      end
      eLen = refLen(mem[modelPc]);
      if (acc) begin
        p1 = modelPc + 16'd1; p2 = modelPc + 16'd2;
        eB = {mem[modelPc], (eLen >= 2'd2) ? mem[p1] : 8'h00, (eLen == 2'd3) ? mem[p2] : 8'h00};
        checks++;
        if (instrPc !== modelPc || instrLen !== eLen || instrBytes !== eB) begin
          failures++;
          $display("FAIL rnd_instr%0d: got pc %h len %0d bytes %h want pc %h len %0d bytes %h",
                   accepted, instrPc, instrLen, instrBytes, modelPc, eLen, eB);
        end
        accepted++;
      end
      if (flush) begin
        modelPc = flushAddr; occ = 0;
      end else begin
        occ = occ + (memStrobe ? 1 : 0) - (acc ? int'(eLen) : 0);
        if (acc) modelPc = modelPc + 16'(eLen);
      end
      bad = (occ > 4 || occ < 0) ? 1 : 0;
      checks++; if (bad != 0) begin failures++; $display("FAIL rnd_occupancy: got %0d want 0..4", occ); end
      nxt();
    end
    flush = 1'b0; instrReady = 1'b0;
    checks++; if (accepted != 1000) begin failures++; $display("FAIL rnd_progress: got %0d want 1000", accepted); end
  endtask

  initial begin
    resetN = 1'b0; flush = 1'b0; flushAddr = '0; instrReady = 1'b0;
    flush8 = 1'b0; flushAddr8 = '0; ready8 = 1'b0;
    for (int i = 0; i < 256; i++) mem8[i] = 8'hFF;
    loadProg();
    #1;
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
